// File: rtl/alu_pkg.sv
// Shared definitions for the datapath ALU slices: op encodings and default width.
package alu_pkg;

   localparam int DEFAULT_WIDTH = 8;

   localparam logic [1:0] OP_AND  = 2'd0;
   localparam logic [1:0] OP_NOT  = 2'd1;
   localparam logic [1:0] OP_TEST = 2'd2;
   localparam logic [1:0] OP_RSVD = 2'd3;

   typedef logic [1:0] op_t;

endpackage

// File: rtl/byte_logic_unit_if.sv
// Operand/result bundle between the ALU issue logic and the byte logic slice.
interface byte_logic_unit_if import alu_pkg::*; #(
   parameter int WIDTH = DEFAULT_WIDTH
) ();

   logic             in_valid;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   op_t              op;
   logic [WIDTH-1:0] result;
   logic             any_set;
   logic             zero;
   logic             out_valid;
   logic             illegal_op;

   modport master (
      output in_valid, a, b, op,
      input  result, any_set, zero, out_valid, illegal_op
   );

   modport slave (
      input  in_valid, a, b, op,
      output result, any_set, zero, out_valid, illegal_op
   );

endinterface

// File: rtl/byte_logic_unit_vec_any_bit_set.sv
// Combinational OR-reduction tree: any_set is 1 when any bit of vec is 1.
module vec_any_bit_set #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] vec,
   output logic             any_set
);

   localparam int LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 0;
   localparam int LEAVES = 1 << LEVELS;

   logic [LEAVES-1:0] lvl;

   // Pairwise in-place reduction; slot k at each level only reads slots >= 2k.
   always_comb begin
      lvl = '0;
      lvl[WIDTH-1:0] = vec;
      for (int s = LEAVES / 2; s >= 1; s = s / 2) begin
         for (int k = 0; k < s; k++) begin
            lvl[k] = lvl[2*k] | lvl[2*k+1];
         end
      end
      any_set = lvl[0];
   end

endmodule

// File: rtl/byte_logic_unit.sv
// Registered logic slice: AND / NOT / TEST of byte operands with zero detect,
// one-cycle latency, valid-qualified.
module byte_logic_unit import alu_pkg::*; #(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input logic              clk,
   input logic              rst,
   byte_logic_unit_if.slave bus
);

   logic [WIDTH-1:0] and_p0;
   logic [WIDTH-1:0] not_p0;
   logic [WIDTH-1:0] result_p0;
   logic             any_p0;
   logic             illegal_p0;

   logic [WIDTH-1:0] result_p1;
   logic             any_p1;
   logic             illegal_p1;
   logic             vld_p1;

   // Stage p0: per-bit gates, op select and zero detect on the next result
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign and_p0[i] = bus.a[i] & bus.b[i];
      assign not_p0[i] = ~bus.a[i];
   end

   always_comb begin
      result_p0 = '0;
      case (bus.op)
         OP_AND:  result_p0 = and_p0;
         OP_NOT:  result_p0 = not_p0;
         OP_TEST: result_p0 = bus.a;
         default: result_p0 = '0;
      endcase
   end

   assign illegal_p0 = (bus.op == OP_RSVD);

   vec_any_bit_set #(
      .WIDTH (WIDTH)
   ) u_any (
      .vec     (result_p0),
      .any_set (any_p0)
   );

   // Stage p1: outputs hold when no input is accepted; reset clears data too
   always_ff @(posedge clk) begin
      if (rst) begin
         result_p1  <= '0;
         any_p1     <= 1'b0;
         illegal_p1 <= 1'b0;
         vld_p1     <= 1'b0;
      end else begin
         vld_p1 <= bus.in_valid;
         if (bus.in_valid) begin
            result_p1  <= result_p0;
            any_p1     <= any_p0;
            illegal_p1 <= illegal_p0;
         end
      end
   end

   assign bus.result     = result_p1;
   assign bus.any_set    = any_p1;
   assign bus.zero       = ~any_p1;
   assign bus.out_valid  = vld_p1;
   assign bus.illegal_op = illegal_p1;

endmodule

// File: tb/tb_byte_logic_unit.sv
// Directed table-driven bench for byte_logic_unit plus short hand-written sequences.
module tb_byte_logic_unit;
   import alu_pkg::*;

   localparam int W = 8;

   logic clk;
   logic rst;

   byte_logic_unit_if #(.WIDTH(W)) bus ();

   byte_logic_unit #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic         r;
      logic         iv;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [1:0]   op;
      logic [W-1:0] e_res;
      logic         e_any;
      logic         e_zero;
      logic         e_vld;
      logic         e_ill;
   } vec_t;

   vec_t vecs[$];
   int   total;
   int   bad;

   task automatic add(input logic r, input logic iv, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [1:0] op,
                      input logic [W-1:0] e_res, input logic e_any,
                      input logic e_zero, input logic e_vld, input logic e_ill);
      vec_t v;
      v.r = r; v.iv = iv; v.a = a; v.b = b; v.op = op;
      v.e_res = e_res; v.e_any = e_any; v.e_zero = e_zero;
      v.e_vld = e_vld; v.e_ill = e_ill;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input int idx,
                      input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s step %0d: got %0h want %0h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic iv, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [1:0] op);
      @(negedge clk);
      rst = r; bus.in_valid = iv; bus.a = a; bus.b = b; bus.op = op;
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input int idx, input logic [W-1:0] e_res,
                            input logic e_any, input logic e_zero,
                            input logic e_vld, input logic e_ill);
      chk("result", idx, 32'(bus.result), 32'(e_res));
      chk("any_set", idx, 32'(bus.any_set), 32'(e_any));
      chk("zero", idx, 32'(bus.zero), 32'(e_zero));
      chk("out_valid", idx, 32'(bus.out_valid), 32'(e_vld));
      chk("illegal_op", idx, 32'(bus.illegal_op), 32'(e_ill));
   endtask

   initial begin
      total = 0;
      bad = 0;
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.op = OP_AND;

      //   rst iv   a      b      op       res    any  zero vld  ill
      add(1, 1, 8'h55, 8'hFF, OP_AND,  8'h00, 0, 1, 0, 0);
      add(1, 1, 8'h55, 8'hFF, OP_AND,  8'h00, 0, 1, 0, 0);
      add(0, 1, 8'h02, 8'h03, OP_AND,  8'h02, 1, 0, 1, 0);
      add(0, 1, 8'h02, 8'h05, OP_AND,  8'h00, 0, 1, 1, 0);
      add(0, 1, 8'h02, 8'hFF, OP_NOT,  8'hFD, 1, 0, 1, 0);
      add(0, 1, 8'hFF, 8'h00, OP_NOT,  8'h00, 0, 1, 1, 0);
      add(0, 1, 8'h00, 8'h00, OP_NOT,  8'hFF, 1, 0, 1, 0);
      add(0, 1, 8'h80, 8'h00, OP_TEST, 8'h80, 1, 0, 1, 0);
      add(0, 1, 8'hAA, 8'hFF, OP_RSVD, 8'h00, 0, 1, 1, 1);
      add(0, 0, 8'h55, 8'h55, OP_AND,  8'h00, 0, 1, 0, 1);
      add(0, 1, 8'hFF, 8'hFF, OP_AND,  8'hFF, 1, 0, 1, 0);
      add(0, 0, 8'h00, 8'h00, OP_NOT,  8'hFF, 1, 0, 0, 0);
      add(1, 1, 8'h0F, 8'hFF, OP_AND,  8'h00, 0, 1, 0, 0);
      add(0, 1, 8'h0F, 8'hFF, OP_AND,  8'h0F, 1, 0, 1, 0);
      add(0, 1, 8'h00, 8'hFF, OP_AND,  8'h00, 0, 1, 1, 0);
      add(0, 1, 8'h00, 8'hFF, OP_TEST, 8'h00, 0, 1, 1, 0);
      add(0, 1, 8'hFF, 8'h00, OP_TEST, 8'hFF, 1, 0, 1, 0);
      add(0, 1, 8'h01, 8'h00, OP_AND,  8'h00, 0, 1, 1, 0);
      add(0, 1, 8'h3C, 8'hC3, OP_RSVD, 8'h00, 0, 1, 1, 1);
      add(0, 1, 8'h7E, 8'h00, OP_NOT,  8'h81, 1, 0, 1, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].r, vecs[i].iv, vecs[i].a, vecs[i].b, vecs[i].op);
         check_all(i, vecs[i].e_res, vecs[i].e_any, vecs[i].e_zero,
                   vecs[i].e_vld, vecs[i].e_ill);
      end

      // Single accepted input followed by idle: one out_valid pulse, data held.
      drive(0, 1, 8'hF0, 8'h3C, OP_AND);
      check_all(100, 8'h30, 1, 0, 1, 0);
      drive(0, 0, 8'h00, 8'h00, OP_RSVD);
      check_all(101, 8'h30, 1, 0, 0, 0);
      drive(0, 0, 8'hFF, 8'hFF, OP_NOT);
      check_all(102, 8'h30, 1, 0, 0, 0);

      // Illegal op then reset while idle clears the flag and the held data.
      drive(0, 1, 8'h11, 8'h22, OP_RSVD);
      check_all(103, 8'h00, 0, 1, 1, 1);
      drive(0, 1, 8'h01, 8'h00, OP_TEST);
      check_all(104, 8'h01, 1, 0, 1, 0);
      drive(1, 0, 8'hFF, 8'hFF, OP_TEST);
      check_all(105, 8'h00, 0, 1, 0, 0);
      drive(0, 1, 8'hC0, 8'hA0, OP_AND);
      check_all(106, 8'h80, 1, 0, 1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
